// File: rtl/eeg_aram_bank_ctrl.sv
// Per-bank ARAM controller: arbitrates loader writes against router read bursts onto one
// single-port SRAM, and returns tagged read data through a credit-managed output FIFO.
module eeg_aram_bank_ctrl #(
   parameter int unsigned ARAM_ADD_AW = 12,
   parameter int unsigned ARAM_DAT_DW = 4,
   parameter int unsigned OBUF_AW     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   AARB_ADD_VLD,
   input  logic                   AARB_ADD_LST,
   output logic                   AARB_ADD_RDY,
   input  logic [ARAM_ADD_AW-1:0] AARB_ADD_ADD,
   output logic                   AARB_DAT_VLD,
   output logic                   AARB_DAT_LST,
   input  logic                   AARB_DAT_RDY,
   output logic [ARAM_DAT_DW-1:0] AARB_DAT_DAT,
   input  logic                   WR_VLD,
   output logic                   WR_RDY,
   input  logic [ARAM_ADD_AW-1:0] WR_ADD,
   input  logic [ARAM_DAT_DW-1:0] WR_DAT,
   output logic                   SRAM_CEN,
   output logic                   SRAM_WEN,
   output logic [ARAM_ADD_AW-1:0] SRAM_ADD,
   output logic [ARAM_DAT_DW-1:0] SRAM_DIN,
   input  logic [ARAM_DAT_DW-1:0] SRAM_DOUT,
   output logic                   BUSY
);

   localparam int unsigned DEPTH = 1 << OBUF_AW;
   localparam int unsigned CW    = OBUF_AW + 1;
   localparam int unsigned EW    = ARAM_DAT_DW + 1;

   typedef enum logic {S_IDLE, S_RBURST} state_e;

   state_e               state_q, state_d;
   logic                 inflight_q, inflight_d;
   logic                 tag_q, tag_d;
   logic [OBUF_AW-1:0]   wptr_q, wptr_d;
   logic [OBUF_AW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]        occ_q, occ_d;
   logic [EW-1:0]        mem_q [DEPTH];
   logic [EW-1:0]        mem_d [DEPTH];

   logic credit_ok;
   logic rd_acc;
   logic wr_acc;
   logic push;
   logic pop;

   // Handshakes and SRAM access; credit uses only registered counts
   always_comb begin
      AARB_ADD_RDY = 1'b0;
      WR_RDY       = 1'b0;
      SRAM_CEN     = 1'b1;
      SRAM_WEN     = 1'b1;
      SRAM_ADD     = '0;
      SRAM_DIN     = '0;
      credit_ok    = (occ_q + CW'(inflight_q)) < CW'(DEPTH);
      if (!rst) begin
         if (state_q == S_IDLE) begin
            WR_RDY       = WR_VLD;
            AARB_ADD_RDY = credit_ok & ~WR_VLD;
         end else begin
            AARB_ADD_RDY = credit_ok;
         end
      end
      rd_acc = AARB_ADD_VLD & AARB_ADD_RDY;
      wr_acc = WR_VLD & WR_RDY;
      if (wr_acc) begin
         SRAM_CEN = 1'b0;
         SRAM_WEN = 1'b0;
         SRAM_ADD = WR_ADD;
         SRAM_DIN = WR_DAT;
      end else if (rd_acc) begin
         SRAM_CEN = 1'b0;
         SRAM_ADD = AARB_ADD_ADD;
      end
   end

   // Next state for FSM, read pipeline and output FIFO
   always_comb begin
      state_d    = state_q;
      inflight_d = rd_acc;
      tag_d      = tag_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      occ_d      = occ_q;
      mem_d      = mem_q;
      push       = inflight_q;
      pop        = AARB_DAT_RDY & (occ_q != '0);

      if (rd_acc) begin
         tag_d   = AARB_ADD_LST;
         state_d = AARB_ADD_LST ? S_IDLE : S_RBURST;
      end
      if (push) begin
         mem_d[wptr_q] = {tag_q, SRAM_DOUT};
         wptr_d        = wptr_q + OBUF_AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + OBUF_AW'(1);
      end
      if (push && !pop) begin
         occ_d = occ_q + CW'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         inflight_q <= 1'b0;
         tag_q      <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         occ_q      <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         occ_q      <= occ_d;
      end
   end

   // Storage needs no reset; occupancy alone qualifies the contents
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      AARB_DAT_VLD = (occ_q != '0);
      {AARB_DAT_LST, AARB_DAT_DAT} = mem_q[rptr_q];
      BUSY = (state_q != S_IDLE) | inflight_q | (occ_q != '0);
   end

endmodule

// File: tb/tb_eeg_aram_bank_ctrl.sv
// Directed bench for eeg_aram_bank_ctrl: behavioural 1-cycle SRAM, reference memory model
// and an in-order scoreboard for returned read beats.
module tb_eeg_aram_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        AARB_ADD_VLD = 1'b0;
   logic        AARB_ADD_LST = 1'b0;
   logic        AARB_ADD_RDY;
   logic [11:0] AARB_ADD_ADD = '0;
   logic        AARB_DAT_VLD;
   logic        AARB_DAT_LST;
   logic        AARB_DAT_RDY = 1'b0;
   logic [3:0]  AARB_DAT_DAT;
   logic        WR_VLD = 1'b0;
   logic        WR_RDY;
   logic [11:0] WR_ADD = '0;
   logic [3:0]  WR_DAT = '0;
   logic        SRAM_CEN;
   logic        SRAM_WEN;
   logic [11:0] SRAM_ADD;
   logic [3:0]  SRAM_DIN;
   logic [3:0]  SRAM_DOUT = '0;
   logic        BUSY;

   eeg_aram_bank_ctrl dut (
      .clk(clk), .rst(rst),
      .AARB_ADD_VLD(AARB_ADD_VLD), .AARB_ADD_LST(AARB_ADD_LST),
      .AARB_ADD_RDY(AARB_ADD_RDY), .AARB_ADD_ADD(AARB_ADD_ADD),
      .AARB_DAT_VLD(AARB_DAT_VLD), .AARB_DAT_LST(AARB_DAT_LST),
      .AARB_DAT_RDY(AARB_DAT_RDY), .AARB_DAT_DAT(AARB_DAT_DAT),
      .WR_VLD(WR_VLD), .WR_RDY(WR_RDY), .WR_ADD(WR_ADD), .WR_DAT(WR_DAT),
      .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_ADD(SRAM_ADD),
      .SRAM_DIN(SRAM_DIN), .SRAM_DOUT(SRAM_DOUT), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   logic [3:0] sram_mem [4096];
   logic [3:0] model    [4096];
   logic [4:0] exp_q [$];
   int         n_vec = 0;
   int         n_err = 0;
   int         pop_cnt = 0;
   logic       rd_acc = 1'b0;
   logic       wr_acc = 1'b0;
   logic       hold_vld = 1'b0;
   logic [4:0] held = '0;

   always @(posedge clk) begin
      if (!SRAM_CEN) begin
         if (!SRAM_WEN) sram_mem[SRAM_ADD] <= SRAM_DIN;
         else           SRAM_DOUT <= sram_mem[SRAM_ADD];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] pat(input int a);
      return 4'(a * 7 + 3);
   endfunction

   // Returned-beat monitor: ordering, LST tag, data, and stability under backpressure
   always @(negedge clk) begin
      #2;
      if (rst) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld && AARB_DAT_VLD) check("dat_hold", {27'd0, AARB_DAT_LST, AARB_DAT_DAT}, {27'd0, held});
         if (AARB_DAT_VLD && AARB_DAT_RDY) begin
            pop_cnt++;
            check("beat_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rd_beat", {27'd0, AARB_DAT_LST, AARB_DAT_DAT}, {27'd0, exp_q.pop_front()});
         end
         hold_vld = AARB_DAT_VLD & ~AARB_DAT_RDY;
         held     = {AARB_DAT_LST, AARB_DAT_DAT};
      end
   end

   // One clock of stimulus; records which handshakes complete at the coming edge
   task automatic cycle(input logic av, input logic al, input int aa,
                        input logic wv, input int wa, input logic [3:0] wd, input logic dr);
      @(negedge clk);
      AARB_ADD_VLD = av;
      AARB_ADD_LST = al;
      AARB_ADD_ADD = 12'(aa);
      WR_VLD       = wv;
      WR_ADD       = 12'(wa);
      WR_DAT       = wd;
      AARB_DAT_RDY = dr;
      #1;
      rd_acc = av & AARB_ADD_RDY;
      wr_acc = wv & WR_RDY;
      if (rd_acc) exp_q.push_back({al, model[12'(aa)]});
      if (wr_acc) model[12'(wa)] = wd;
   endtask

   task automatic idle(input logic dr);
      cycle(1'b0, 1'b0, 0, 1'b0, 0, 4'h0, dr);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0 && !BUSY) break;
         idle(1'b1);
      end
      check("drain_pending", 32'(exp_q.size()), 0);
      check("drain_busy", 32'(BUSY), 0);
   endtask

   task automatic write_word(input int a, input logic [3:0] d);
      cycle(1'b0, 1'b0, 0, 1'b1, a, d, 1'b1);
      check("wr_grant", 32'(wr_acc), 1);
   endtask

   initial begin
      int issued;
      int p0;

      // Reset values
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst_dat_vld", 32'(AARB_DAT_VLD), 0);
      check("rst_add_rdy", 32'(AARB_ADD_RDY), 0);
      check("rst_wr_rdy",  32'(WR_RDY), 0);
      check("rst_cen",     32'(SRAM_CEN), 1);
      check("rst_wen",     32'(SRAM_WEN), 1);
      check("rst_add",     32'(SRAM_ADD), 0);
      check("rst_din",     32'(SRAM_DIN), 0);
      check("rst_busy",    32'(BUSY), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int a = 0; a < 32; a++) write_word(a, pat(a));

      // 1: streaming burst 0..7 with consumer always ready
      p0 = pop_cnt;
      for (int k = 0; k < 8; k++) begin
         cycle(1'b1, k == 7, k, 1'b0, 0, 4'h0, 1'b1);
         check("t1_accept", 32'(rd_acc), 1);
         if (k < 2)  check("t1_vld_early", 32'(AARB_DAT_VLD), 0);
         if (k == 2) check("t1_vld_first", 32'(AARB_DAT_VLD), 1);
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      check("t1_beats", 32'(pop_cnt - p0), 8);
      check("t1_busy_idle", 32'(BUSY), 0);

      // 2: backpressure limits acceptance to the buffer depth
      p0 = pop_cnt;
      issued = 0;
      for (int s = 0; s < 100; s++) begin
         if (issued == 8) break;
         cycle(1'b1, issued == 7, 8 + issued, 1'b0, 0, 4'h0, s >= 10);
         if (rd_acc) issued++;
         if (s == 6) begin
            check("t2_accepted", 32'(issued), 4);
            check("t2_add_rdy", 32'(AARB_ADD_RDY), 0);
         end
      end
      check("t2_issued", 32'(issued), 8);
      drain();
      check("t2_beats", 32'(pop_cnt - p0), 8);

      // 3: simultaneous write and read in IDLE, write wins
      cycle(1'b1, 1'b1, 5, 1'b1, 'h200, 4'h9, 1'b1);
      check("t3_wr_rdy", 32'(WR_RDY), 1);
      check("t3_add_rdy", 32'(AARB_ADD_RDY), 0);
      check("t3_wen", 32'(SRAM_WEN), 0);
      check("t3_sram_add", 32'(SRAM_ADD), 'h200);
      cycle(1'b1, 1'b1, 5, 1'b0, 0, 4'h0, 1'b1);
      check("t3_rd_accept", 32'(rd_acc), 1);
      check("t3_rd_wen", 32'(SRAM_WEN), 1);
      check("t3_rd_add", 32'(SRAM_ADD), 5);
      drain();

      // 4: write held off until the LST beat is accepted
      cycle(1'b1, 1'b0, 'h10, 1'b0, 0, 4'h0, 1'b1);
      for (int k = 1; k < 4; k++) begin
         cycle(1'b1, k == 3, 'h10 + k, 1'b1, 'h40, 4'hC, 1'b1);
         check("t4_wr_blocked", 32'(WR_RDY), 0);
         check("t4_rd_accept", 32'(rd_acc), 1);
      end
      cycle(1'b0, 1'b0, 0, 1'b1, 'h40, 4'hC, 1'b1);
      check("t4_wr_granted", 32'(wr_acc), 1);
      check("t4_wen", 32'(SRAM_WEN), 0);
      cycle(1'b1, 1'b1, 'h40, 1'b0, 0, 4'h0, 1'b1);
      drain();

      // 5: read-after-write to the same address in the next cycle
      cycle(1'b0, 1'b0, 0, 1'b1, 'h123, 4'h5, 1'b0);
      check("t5_wr", 32'(wr_acc), 1);
      cycle(1'b1, 1'b1, 'h123, 1'b0, 0, 4'h0, 1'b0);
      check("t5_rd", 32'(rd_acc), 1);
      idle(1'b0);
      check("t5_vld_early", 32'(AARB_DAT_VLD), 0);
      idle(1'b0);
      check("t5_vld", 32'(AARB_DAT_VLD), 1);
      check("t5_dat", 32'(AARB_DAT_DAT), 5);
      check("t5_lst", 32'(AARB_DAT_LST), 1);
      drain();

      // 6: reset with three beats buffered and one in flight
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 1'b0, 20 + k, 1'b0, 0, 4'h0, 1'b0);
         check("t6_accept", 32'(rd_acc), 1);
      end
      @(negedge clk);
      rst = 1'b1;
      AARB_ADD_VLD = 1'b0;
      AARB_DAT_RDY = 1'b0;
      exp_q.delete();
      #1;
      check("t6_busy_pre", 32'(BUSY), 1);
      cycle(1'b0, 1'b0, 0, 1'b1, 'h300, 4'h6, 1'b0);
      check("t6_busy_pre2", 32'(BUSY), 0);
      @(negedge clk);
      rst = 1'b0;
      WR_VLD = 1'b0;
      #1;
      check("t6_dat_vld", 32'(AARB_DAT_VLD), 0);
      check("t6_busy", 32'(BUSY), 0);
      cycle(1'b0, 1'b0, 0, 1'b1, 'h300, 4'h6, 1'b0);
      check("t6_idle_wr_rdy", 32'(WR_RDY), 1);
      check("t6_idle_add_rdy", 32'(AARB_ADD_RDY), 0);
      p0 = pop_cnt;
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, k == 3, 24 + k, 1'b0, 0, 4'h0, 1'b1);
         check("t6_post_accept", 32'(rd_acc), 1);
      end
      drain();
      check("t6_post_beats", 32'(pop_cnt - p0), 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
